// File: rtl/wb_pkg.sv
// Shared definitions for the writeback result arbiter.
//   - Payload layout (MSB first): val32 | rd5 | sel3 | rd_wen1 | PC32 | ETW3
//   - Branch-id width, functional-unit index constants
//   - Output-register state encoding and the flush squash helper
package wb_pkg;

  localparam int PLD_W   = 76;
  localparam int BID_W   = 4;

  // Field offsets inside the 76-bit payload
  localparam int VAL_LSB = 44;  // [75:44]
  localparam int RD_LSB  = 39;  // [43:39]
  localparam int SEL_LSB = 36;  // [38:36]
  localparam int WEN_BIT = 35;  // [35]
  localparam int PC_LSB  = 3;   // [34:3]
  localparam int ETW_LSB = 0;   // [2:0]

  localparam int FU_ALU  = 0;
  localparam int FU_BRU  = 1;
  localparam int FU_LSU  = 2;
  localparam int FU_MDU  = 3;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // A result is squashed by a flush unless it is the delay slot of the
  // flushing branch itself.
  function automatic logic squash(input logic flush_valid,
                                  input logic is_delayslot,
                                  input logic bid_match);
    return flush_valid & ~(is_delayslot & bid_match);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant (zero when no request)
//   idx   : encoded index of the granted requester
module rr_arbiter #(
  parameter int NUM = 4
) (
  input  logic [NUM-1:0] req,
  input  logic [2:0]     ptr,
  output logic [NUM-1:0] grant,
  output logic [2:0]     idx
);

  logic found;
  int   j;

  // Walk upward from ptr, wrapping modulo NUM; first request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM; k++) begin
      j = (int'(ptr) + k) % NUM;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = 3'(j);
      end
    end
  end

endmodule

// File: rtl/wb_res_arbiter.sv
// Merges NUM_FU functional-unit result streams into the single WBU
// writeback port through a one-entry output register, round-robin
// arbitration, and flush squashing of both inputs and the held entry.
//   s_*     : per-FU result inputs (valid/ready, payload, delay-slot, branch_id)
//   m_*     : registered winner towards the WBU (valid/ready)
//   flush_* : WBU flush strobe and the branch_id of the flushing branch
// Handshake: a transfer happens on any cycle where valid & ready are both
// high; valid never waits for ready, and a held m_payload is stable while
// m_valid & !m_ready.
module wb_res_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PLD_W  = wb_pkg::PLD_W,
  parameter int BID_W  = wb_pkg::BID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       s_valid,
  output logic [NUM_FU-1:0]       s_ready,
  input  logic [NUM_FU*PLD_W-1:0] s_payload,
  input  logic [NUM_FU-1:0]       s_is_delayslot,
  input  logic [NUM_FU*BID_W-1:0] s_branch_id,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PLD_W-1:0]        m_payload,
  output logic                    m_is_delayslot,
  output logic [BID_W-1:0]        m_branch_id,
  output logic [2:0]              m_src,
  input  logic                    flush_valid,
  input  logic [BID_W-1:0]        flush_branch_id
);
  import wb_pkg::*;

  out_state_e        state_q, state_d;
  logic [2:0]        rr_ptr;
  logic [NUM_FU-1:0] in_sq;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [2:0]        win_idx;
  logic              out_full;
  logic              m_squash;
  logic              can_load;
  logic              load;
  logic [PLD_W-1:0]  win_payload;
  logic              win_ds;
  logic [BID_W-1:0]  win_bid;

  // Squashed inputs are removed from arbitration before the grant.
  always_comb begin
    in_sq = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      in_sq[i] = squash(flush_valid, s_is_delayslot[i],
                        s_branch_id[i*BID_W +: BID_W] == flush_branch_id);
    end
  end

  assign req = s_valid & ~in_sq;

  rr_arbiter #(.NUM(NUM_FU)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // One-hot mux of the winner's fields.
  always_comb begin
    win_payload = '0;
    win_ds      = 1'b0;
    win_bid     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win_payload = s_payload[i*PLD_W +: PLD_W];
        win_ds      = s_is_delayslot[i];
        win_bid     = s_branch_id[i*BID_W +: BID_W];
      end
    end
  end

  assign out_full = (state_q == OUT_FULL);
  assign m_squash = out_full & squash(flush_valid, m_is_delayslot,
                                      m_branch_id == flush_branch_id);
  assign m_valid  = out_full & ~m_squash;
  // The register can take a new entry if empty, draining this cycle, or
  // being discarded by a flush this cycle.
  assign can_load = ~out_full | (m_ready & m_valid) | m_squash;
  assign load     = (|grant) & can_load & ~rst;

  // Squashed inputs are drained unconditionally so they never stall.
  assign s_ready  = rst ? '0 : ((grant & {NUM_FU{can_load}}) | (s_valid & in_sq));

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = OUT_FULL;
    else if ((m_ready & m_valid) | m_squash)
      state_d = OUT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      m_payload      <= '0;
      m_is_delayslot <= 1'b0;
      m_branch_id    <= '0;
      m_src          <= '0;
    end else if (load) begin
      rr_ptr         <= (win_idx == 3'(NUM_FU - 1)) ? 3'd0 : win_idx + 3'd1;
      m_payload      <= win_payload;
      m_is_delayslot <= win_ds;
      m_branch_id    <= win_bid;
      m_src          <= win_idx;
    end
  end

endmodule

// File: tb/tb_wb_res_arbiter.sv
// Bench for wb_res_arbiter: directed scenarios followed by randomized
// traffic compared against a queue-based reference model.
module tb_wb_res_arbiter;
  import wb_pkg::*;

  localparam int N  = 4;
  localparam int PW = wb_pkg::PLD_W;
  localparam int BW = wb_pkg::BID_W;
  localparam int EW = 3 + 1 + BW + PW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*PW-1:0] s_payload;
  logic [N-1:0]    s_is_delayslot;
  logic [N*BW-1:0] s_branch_id;
  logic            m_valid;
  logic            m_ready;
  logic [PW-1:0]   m_payload;
  logic            m_is_delayslot;
  logic [BW-1:0]   m_branch_id;
  logic [2:0]      m_src;
  logic            flush_valid;
  logic [BW-1:0]   flush_branch_id;

  int checks = 0;
  int errors = 0;

  wb_res_arbiter #(.NUM_FU(N), .PLD_W(PW), .BID_W(BW)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_payload       (s_payload),
    .s_is_delayslot  (s_is_delayslot),
    .s_branch_id     (s_branch_id),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_payload       (m_payload),
    .m_is_delayslot  (m_is_delayslot),
    .m_branch_id     (m_branch_id),
    .m_src           (m_src),
    .flush_valid     (flush_valid),
    .flush_branch_id (flush_branch_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_valid         = '0;
    s_payload       = '0;
    s_is_delayslot  = '0;
    s_branch_id     = '0;
    m_ready         = 1'b0;
    flush_valid     = 1'b0;
    flush_branch_id = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_fu(input int i, input logic [PW-1:0] p,
                        input logic ds, input logic [BW-1:0] bid);
    s_payload[i*PW +: PW]   = p;
    s_is_delayslot[i]       = ds;
    s_branch_id[i*BW +: BW] = bid;
  endtask

  function automatic logic [PW-1:0] pld_with_val(input logic [31:0] v);
    logic [PW-1:0] p;
    p = '0;
    p[VAL_LSB +: 32] = v;
    return p;
  endfunction

  // ---------------- reference model ----------------
  // exp_q holds the output register contents ({src, ds, bid, payload});
  // it is empty or holds exactly one entry.
  logic [EW-1:0] exp_q[$];
  int            mdl_ptr;
  int            mdl_win;
  bit            mdl_can_load;
  bit            mdl_hsq;
  bit            exp_mvalid;
  logic [N-1:0]  exp_ready;

  function automatic bit mdl_sq(input bit d, input logic [BW-1:0] b);
    return flush_valid && !(d && (b == flush_branch_id));
  endfunction

  task automatic mdl_eval();
    bit            held;
    logic [EW-1:0] e;
    held    = (exp_q.size() > 0);
    mdl_hsq = 1'b0;
    if (held) begin
      e       = exp_q[0];
      mdl_hsq = mdl_sq(e[PW+BW], e[PW+BW-1:PW]);
    end
    exp_mvalid   = held && !mdl_hsq;
    mdl_can_load = !held || (m_ready && exp_mvalid) || mdl_hsq;
    mdl_win = -1;
    for (int k = 0; k < N; k++) begin
      int jj;
      jj = (mdl_ptr + k) % N;
      if (mdl_win < 0 && s_valid[jj] &&
          !mdl_sq(s_is_delayslot[jj], s_branch_id[jj*BW +: BW]))
        mdl_win = jj;
    end
    exp_ready = '0;
    if (!rst) begin
      for (int i = 0; i < N; i++)
        exp_ready[i] = ((i == mdl_win) && mdl_can_load) ||
                       (s_valid[i] && mdl_sq(s_is_delayslot[i], s_branch_id[i*BW +: BW]));
    end
  endtask

  task automatic mdl_commit();
    if (rst) begin
      exp_q.delete();
      mdl_ptr = 0;
    end else if (mdl_win >= 0 && mdl_can_load) begin
      exp_q.delete();
      exp_q.push_back({3'(mdl_win), s_is_delayslot[mdl_win],
                       s_branch_id[mdl_win*BW +: BW], s_payload[mdl_win*PW +: PW]});
      mdl_ptr = (mdl_win + 1) % N;
    end else if ((m_ready && exp_mvalid) || mdl_hsq) begin
      exp_q.delete();
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    clear_inputs();
    rst     = 1'b1;
    s_valid = 4'b1111;
    m_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (s_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_s_ready cyc%0d: got %b want 0000", c, s_ready);
      end
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_m_valid cyc%0d: got %b want 0", c, m_valid);
      end
    end
    checks++;
    if (m_payload !== '0 || m_src !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: payload %h src %0d want 0/0", m_payload, m_src);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ptr_zero: s_ready %b want 0001", s_ready);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, pld_with_val(32'(i + 16'h100)), 1'b0, '0);
    s_valid = 4'b1111;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_src !== 3'(k % 4) ||
          m_payload[VAL_LSB +: 32] !== 32'(k % 4 + 16'h100)) begin
        errors++;
        $display("FAIL rr_seq step%0d: valid %b src %0d val %h want 1/%0d", k,
                 m_valid, m_src, m_payload[VAL_LSB +: 32], k % 4);
      end
      checks++;
      if (s_ready !== 4'(1 << ((k + 1) % 4))) begin
        errors++;
        $display("FAIL rr_ready step%0d: got %b want %b", k, s_ready, 4'(1 << ((k + 1) % 4)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_fu(FU_ALU, pld_with_val(32'h1234), 1'b0, 4'd0);
    set_fu(FU_LSU, pld_with_val(32'hABCD), 1'b0, 4'd0);
    s_valid = 4'b0101;
    m_ready = 1'b0;
    tick();
    s_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (s_ready !== 4'b0000 || m_valid !== 1'b1 || m_payload[VAL_LSB +: 32] !== 32'h1234) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: s_ready %b m_valid %b val %h want 0000/1/1234",
                 c, s_ready, m_valid, m_payload[VAL_LSB +: 32]);
      end
      tick();
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 0100", s_ready);
    end
    tick();
    s_valid = 4'b0000;
    checks++;
    if (m_valid !== 1'b1 || m_src !== 3'd2 || m_payload[VAL_LSB +: 32] !== 32'hABCD) begin
      errors++;
      $display("FAIL bp_lsu_next: valid %b src %0d val %h want 1/2/abcd",
               m_valid, m_src, m_payload[VAL_LSB +: 32]);
    end
  endtask

  task automatic test_flush_held();
    do_reset();
    set_fu(FU_ALU, pld_with_val(32'h55), 1'b0, 4'd3);
    s_valid = 4'b0001;
    tick();
    s_valid = 4'b0000;
    #1;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_held_pre: m_valid %b want 1", m_valid);
    end
    flush_valid     = 1'b1;
    flush_branch_id = 4'd3;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_held_drop: m_valid %b want 0", m_valid);
    end
    tick();
    flush_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_held_cleared: m_valid %b want 0", m_valid);
    end
  endtask

  task automatic test_delayslot();
    do_reset();
    set_fu(FU_ALU, pld_with_val(32'h77), 1'b1, 4'd3);
    s_valid = 4'b0001;
    tick();
    s_valid         = 4'b0000;
    flush_valid     = 1'b1;
    flush_branch_id = 4'd3;
    #1;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL ds_survive: m_valid %b want 1", m_valid);
    end
    tick();
    flush_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_payload[VAL_LSB +: 32] !== 32'h77) begin
      errors++;
      $display("FAIL ds_survive_after: m_valid %b val %h want 1/77", m_valid, m_payload[VAL_LSB +: 32]);
    end
    do_reset();
    set_fu(FU_ALU, pld_with_val(32'h88), 1'b1, 4'd2);
    s_valid = 4'b0001;
    tick();
    s_valid         = 4'b0000;
    flush_valid     = 1'b1;
    flush_branch_id = 4'd3;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL ds_other_bid_drop: m_valid %b want 0", m_valid);
    end
    tick();
    flush_valid = 1'b0;
  endtask

  task automatic test_flush_input();
    do_reset();
    set_fu(FU_ALU, pld_with_val(32'hA1A1), 1'b1, 4'd5);
    set_fu(FU_BRU, pld_with_val(32'hB2B2), 1'b0, 4'd1);
    s_valid         = 4'b0011;
    m_ready         = 1'b1;
    flush_valid     = 1'b1;
    flush_branch_id = 4'd5;
    #1;
    checks++;
    if (s_ready !== 4'b0011) begin
      errors++;
      $display("FAIL flush_in_ready: got %b want 0011", s_ready);
    end
    tick();
    s_valid     = 4'b0000;
    flush_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_src !== 3'd0 || m_payload !== pld_with_val(32'hA1A1)) begin
      errors++;
      $display("FAIL flush_in_alu: valid %b src %0d val %h want 1/0/a1a1",
               m_valid, m_src, m_payload[VAL_LSB +: 32]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [95:0] r;
    do_reset();
    exp_q.delete();
    mdl_ptr = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        r = {$urandom, $urandom, $urandom};
        set_fu(i, r[PW-1:0], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
      end
      s_valid         = 4'($urandom_range(0, 15));
      m_ready         = ($urandom_range(0, 3) != 0);
      flush_valid     = ($urandom_range(0, 4) == 0);
      flush_branch_id = 4'($urandom_range(0, 3));
      #1;
      mdl_eval();
      checks++;
      if (s_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_s_ready cyc%0d: got %b want %b", c, s_ready, exp_ready);
      end
      checks++;
      if (m_valid !== exp_mvalid) begin
        errors++;
        $display("FAIL rand_m_valid cyc%0d: got %b want %b", c, m_valid, exp_mvalid);
      end
      if (exp_mvalid) begin
        checks++;
        if ({m_src, m_is_delayslot, m_branch_id, m_payload} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_m_data cyc%0d: got %h want %h", c,
                   {m_src, m_is_delayslot, m_branch_id, m_payload}, exp_q[0]);
        end
      end
      @(posedge clk);
      mdl_commit();
      #1;
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_flush_held();
    test_delayslot();
    test_flush_input();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
